// File: rtl/sbus_mem_resp_if.sv
// sbus_mem_resp_if: memory-bus request/response signals between initiator and memory responder
interface sbus_mem_resp_if;
    logic         start_a;
    logic         start_b;
    logic         rd_rq;
    logic         wr_rq;
    logic [0:3]   rq;
    logic [14:35] adr;
    logic         adr_par;
    logic [0:35]  data_in;
    logic         data_par_in;
    logic         ackn;
    logic         data_valid;
    logic [0:35]  data_out;
    logic         data_par_out;
    logic         wr_stb;
    logic         adr_par_err;
    logic         mem_error;
    logic         busy;

    modport master (
        output start_a, start_b, rd_rq, wr_rq, rq, adr, adr_par, data_in, data_par_in,
        input  ackn, data_valid, data_out, data_par_out, wr_stb, adr_par_err, mem_error, busy
    );

    modport slave (
        input  start_a, start_b, rd_rq, wr_rq, rq, adr, adr_par, data_in, data_par_in,
        output ackn, data_valid, data_out, data_par_out, wr_stb, adr_par_err, mem_error, busy
    );
endinterface

// File: rtl/sbus_mem_resp.sv
// sbus_mem_resp: quad-word memory responder with programmable ack/data latency,
// read, write and read-pause-write cycles, address/data parity checking.
module sbus_mem_resp #(
    parameter int MEM_WORDS  = 65536,
    parameter int ACK_DELAY  = 2,
    parameter int WORD_DELAY = 1
) (
    input logic       clk,
    input logic       reset,
    sbus_mem_resp_if.slave bus
);
    localparam int AW = $clog2(MEM_WORDS);
    localparam logic [4:0] ACK_CNT  = 5'(ACK_DELAY);
    localparam logic [4:0] XFER_CNT = 5'(ACK_DELAY + WORD_DELAY - 1);

    typedef enum logic [2:0] {IDLE, ACK_WAIT, XFER_RD, GAP, XFER_WR} state_t;

    state_t       state, state_n;
    logic [4:0]   cnt, cnt_n;
    logic [0:3]   rem, rem_n, rq_q;
    logic [14:35] adr_q;
    logic         adr_par_q, rd_q, wr_q, merr_q;
    logic         start, perr, nxm, noop, in_range, wr_stb, data_valid;
    logic [1:0]   pos;
    logic [21:0]  waddr;
    logic [0:35]  rd_word;
    logic [0:35]  mem [MEM_WORDS] = '{default: '0};

    // first still-pending quad position, scanning cyclically from the start word
    function automatic logic [1:0] first_pos(input logic [1:0] s, input logic [0:3] m);
        first_pos = s;
        for (int k = 3; k >= 0; k--)
            if (m[s + 2'(k)]) first_pos = s + 2'(k);
    endfunction

    assign start    = bus.start_a | bus.start_b;
    assign perr     = ~^{adr_q, adr_par_q};
    assign nxm      = 32'(adr_q) >= MEM_WORDS;
    assign noop     = (rq_q == '0) || !(rd_q || wr_q);
    assign pos      = first_pos(adr_q[34:35], rem);
    assign waddr    = {adr_q[14:33], pos};
    assign in_range = 32'(waddr) < MEM_WORDS;
    assign rd_word  = in_range ? mem[waddr[AW-1:0]] : '0;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        rem_n   = rem;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = ACK_WAIT;
                    cnt_n   = 5'd1;
                end
            end
            ACK_WAIT: begin
                cnt_n = cnt + 5'd1;
                if (perr || nxm || (noop && cnt == ACK_CNT))
                    state_n = IDLE;
                else if (cnt == XFER_CNT) begin
                    state_n = rd_q ? XFER_RD : XFER_WR;
                    rem_n   = rq_q;
                end
            end
            XFER_RD, XFER_WR: begin
                rem_n[pos] = 1'b0;
                if (rem_n == '0)
                    state_n = (state == XFER_RD && wr_q) ? GAP : IDLE;
            end
            GAP: begin
                state_n = XFER_WR;
                rem_n   = rq_q;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        state  <= reset ? IDLE : state_n;
        cnt    <= cnt_n;
        rem    <= rem_n;
        merr_q <= wr_stb && !(^{bus.data_in, bus.data_par_in});
        if (!reset && state == IDLE && start) begin
            rd_q      <= bus.rd_rq;
            wr_q      <= bus.wr_rq;
            rq_q      <= bus.rq;
            adr_q     <= bus.adr;
            adr_par_q <= bus.adr_par;
        end
    end

    // memory has no reset: contents survive RESET
    always_ff @(posedge clk)
        if (wr_stb && in_range) mem[waddr[AW-1:0]] <= bus.data_in;

    // reset gates every output, which also blocks a write strobe coinciding with RESET
    assign data_valid       = !reset && state == XFER_RD;
    assign wr_stb           = !reset && state == XFER_WR;
    assign bus.data_valid   = data_valid;
    assign bus.wr_stb       = wr_stb;
    assign bus.data_out     = data_valid ? rd_word : '0;
    assign bus.data_par_out = data_valid && !(^rd_word);
    assign bus.ackn         = !reset && state == ACK_WAIT && cnt == ACK_CNT && !perr && !nxm;
    assign bus.adr_par_err  = !reset && state == ACK_WAIT && perr;
    assign bus.mem_error    = !reset && merr_q;
    assign bus.busy         = !reset && state != IDLE;
endmodule

// File: tb/tb_sbus_mem_resp.sv
// tb_sbus_mem_resp: directed timeline checks plus read-data scoreboard for sbus_mem_resp
module tb_sbus_mem_resp;
    localparam int MW = 4096;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    sbus_mem_resp_if bus();
    sbus_mem_resp #(.MEM_WORDS(MW), .ACK_DELAY(2), .WORD_DELAY(1)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    int vectors = 0;
    int miscompares = 0;
    logic [35:0] model [MW];
    logic [35:0] wdat [4];
    logic [35:0] sb [$];

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] widx(input logic [21:0] a, input int p);
        return 12'({a[21:2], 2'(p)});
    endfunction

    task automatic idle_inputs;
        bus.start_a = 0; bus.start_b = 0; bus.rd_rq = 0; bus.wr_rq = 0;
        bus.rq = '0; bus.adr = '0; bus.adr_par = 1; bus.data_in = '0; bus.data_par_in = 1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ackn"}, 64'(bus.ackn), 0);
        chk({tag, "_dv"}, 64'(bus.data_valid), 0);
        chk({tag, "_dout"}, 64'(bus.data_out), 0);
        chk({tag, "_dpar"}, 64'(bus.data_par_out), 0);
        chk({tag, "_wstb"}, 64'(bus.wr_stb), 0);
        chk({tag, "_aperr"}, 64'(bus.adr_par_err), 0);
        chk({tag, "_merr"}, 64'(bus.mem_error), 0);
        chk({tag, "_busy"}, 64'(bus.busy), 0);
    endtask

    // Starts a transaction in the current cycle and checks every cycle up to the
    // first idle one, leaving the bench in that idle cycle so the next call is back-to-back.
    task automatic xfer(input logic rd, input logic wr, input logic [3:0] r, input logic [21:0] a,
                        input logic bad_ap, input logic [3:0] bad_dp, input logic use_b);
        int ord [4];
        int n = 0;
        bit ok, act, wcyc, prevw;
        int last, ws0;
        for (int k = 0; k < 4; k++) begin
            int p = (int'(a[1:0]) + k) % 4;
            if (r[3-p]) begin ord[n] = p; n++; end
        end
        ok   = !bad_ap && int'(a) < MW;
        act  = ok && n > 0 && (rd || wr);
        ws0  = rd ? 4 + n : 3;
        last = !ok ? 1 : !act ? 2 : (rd && wr) ? 3 + 2 * n : 2 + n;
        bus.start_a = !use_b; bus.start_b = use_b;
        bus.rd_rq = rd; bus.wr_rq = wr; bus.rq = r; bus.adr = a; bus.adr_par = ~^a ^ bad_ap;
        #1 chk("start_idle_busy", 64'(bus.busy), 0);
        if (act && rd)
            for (int j = 0; j < n; j++) sb.push_back(model[widx(a, ord[j])]);
        tick;
        bus.start_a = 0; bus.start_b = 0;
        bus.rd_rq = !rd; bus.wr_rq = !wr; bus.rq = ~r; bus.adr = ~a;
        for (int c = 1; c <= last + 1; c++) begin
            wcyc  = act && wr && c >= ws0 && c < ws0 + n;
            prevw = act && wr && c - 1 >= ws0 && c - 1 < ws0 + n;
            if (wcyc) begin
                bus.data_in = wdat[c-ws0];
                bus.data_par_in = ~^wdat[c-ws0] ^ bad_dp[c-ws0];
                model[widx(a, ord[c-ws0])] = wdat[c-ws0];
            end else begin
                bus.data_in = 36'(c * 7 + 1);
                bus.data_par_in = 0;
            end
            #1;
            chk("ackn", 64'(bus.ackn), 64'(ok && c == 2));
            chk("data_valid", 64'(bus.data_valid), 64'(act && rd && c >= 3 && c < 3 + n));
            chk("wr_stb", 64'(bus.wr_stb), 64'(wcyc));
            chk("busy", 64'(bus.busy), 64'(c <= last));
            chk("adr_par_err", 64'(bus.adr_par_err), 64'(bad_ap && c == 1));
            chk("mem_error", 64'(bus.mem_error), 64'(prevw ? bad_dp[c-1-ws0] : 1'b0));
            if (c <= last) tick;
        end
    endtask

    always @(negedge clk) begin
        if (bus.data_valid) begin
            logic [35:0] e;
            e = sb.size() > 0 ? sb.pop_front() : 'x;
            chk("read_data", 64'(bus.data_out), 64'(e));
            chk("read_parity", 64'(bus.data_par_out), 64'(~^e));
        end else begin
            chk("idle_dout", 64'(bus.data_out), 0);
        end
    end

    initial begin
        for (int i = 0; i < MW; i++) model[i] = '0;
        idle_inputs();
        tick; tick;
        check_zero("reset");
        // START coinciding with RESET is ignored
        bus.start_a = 1; bus.rd_rq = 1; bus.rq = 4'b1111; bus.adr = 22'o100; bus.adr_par = ~^22'o100;
        tick;
        reset = 0;
        idle_inputs();
        #1 chk("rst_start_busy", 64'(bus.busy), 0);
        tick;
        #1 chk("rst_start_ackn", 64'(bus.ackn), 0);
        chk("rst_start_busy2", 64'(bus.busy), 0);

        wdat = '{36'd1, 36'd2, 36'd3, 36'd4};
        xfer(0, 1, 4'b1111, 22'o100, 0, 4'b0000, 0);
        xfer(1, 0, 4'b1011, 22'o102, 0, 4'b0000, 1);
        xfer(1, 0, 4'b1111, 22'(MW), 0, 4'b0000, 0);
        wdat = '{36'd9, 36'd9, 36'd9, 36'd9};
        xfer(0, 1, 4'b1111, 22'o100, 1, 4'b0000, 0);
        xfer(1, 0, 4'b1111, 22'o100, 0, 4'b0000, 0);
        wdat[0] = 36'h5_A5A5_A5A5;
        xfer(1, 1, 4'b0001, 22'o200, 0, 4'b0001, 0);
        xfer(1, 0, 4'b0001, 22'o200, 0, 4'b0000, 1);
        xfer(1, 0, 4'b0000, 22'o100, 0, 4'b0000, 0);
        xfer(0, 0, 4'b1111, 22'o100, 0, 4'b0000, 0);
        wdat = '{36'hF_0000_0001, 36'h0_1234_5678, 36'h8_0000_0000, 36'h7_FFFF_FFFF};
        xfer(1, 1, 4'b0110, 22'o407, 0, 4'b0010, 1);
        xfer(1, 0, 4'b1111, 22'o404, 0, 4'b0000, 0);

        // RESET on the second write strobe: only the first word lands
        bus.start_a = 1; bus.wr_rq = 1; bus.rq = 4'b1111; bus.adr = 22'o300; bus.adr_par = ~^22'o300;
        tick;
        idle_inputs();
        tick; tick;
        bus.data_in = 36'hA_AAAA_AAAA; bus.data_par_in = ~^36'hA_AAAA_AAAA;
        #1 chk("rst_wr_first_stb", 64'(bus.wr_stb), 1);
        tick;
        bus.data_in = 36'hB_BBBB_BBBB; bus.data_par_in = ~^36'hB_BBBB_BBBB;
        reset = 1;
        #1 check_zero("rst_wr");
        tick;
        reset = 0;
        idle_inputs();
        model[12'o300] = 36'hA_AAAA_AAAA;
        xfer(1, 0, 4'b1111, 22'o300, 0, 4'b0000, 0);

        chk("scoreboard_empty", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
